// File: rtl/uart_rx_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_frame_ctrl_if
//  Description : Pin-path, sampler and data-sink signals of the RX frame controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_frame_ctrl_if #(
  parameter int COUNTER_WIDTH  = 4,
  parameter int PRESCALE_WIDTH = 5,
  parameter int DATA_WIDTH     = 8
);
  logic                      RX_IN;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic [PRESCALE_WIDTH-1:0] Prescale;
  logic                      valid_sampled_bit;
  logic                      sampled_bit;
  logic                      data_sampling_enable;
  logic [PRESCALE_WIDTH-1:0] sample_counter;
  logic [COUNTER_WIDTH-1:0]  bit_counter;
  logic [DATA_WIDTH-1:0]     P_DATA;
  logic                      data_valid;
  logic                      parity_error;
  logic                      stop_error;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP, Prescale, valid_sampled_bit, sampled_bit,
    input  data_sampling_enable, sample_counter, bit_counter, P_DATA,
           data_valid, parity_error, stop_error
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP, Prescale, valid_sampled_bit, sampled_bit,
    output data_sampling_enable, sample_counter, bit_counter, P_DATA,
           data_valid, parity_error, stop_error
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_frame_ctrl
//  Description : UART RX framing FSM: start detect, oversample counters,
//                LSB-first deserialisation, parity and stop checking.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_frame_ctrl #(
  parameter int COUNTER_WIDTH  = 4,
  parameter int PRESCALE_WIDTH = 5,
  parameter int DATA_WIDTH     = 8
) (
  input wire logic             CLK,
  input wire logic             RST,
  uart_rx_frame_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic [PRESCALE_WIDTH-1:0] c_PS_ONE        = PRESCALE_WIDTH'(1);
  localparam logic [COUNTER_WIDTH-1:0]  c_BIT_ONE       = COUNTER_WIDTH'(1);
  localparam logic [COUNTER_WIDTH-1:0]  c_LAST_DATA_BIT = COUNTER_WIDTH'(DATA_WIDTH);

  state_t                    r_state;
  logic [PRESCALE_WIDTH-1:0] r_sample_cnt;
  logic [COUNTER_WIDTH-1:0]  r_bit_cnt;
  logic [DATA_WIDTH-1:0]     r_shift;
  logic [DATA_WIDTH-1:0]     r_p_data;
  logic                      r_par_en;
  logic                      r_par_typ;
  logic                      r_data_valid;
  logic                      r_parity_error;
  logic                      r_stop_error;

  logic w_last_sample;
  logic w_take_bit;
  logic w_expected_parity;

  assign w_last_sample     = (r_sample_cnt == (bus.Prescale - c_PS_ONE));
  // Sampler pulses landing anywhere but the last oversample are discarded.
  assign w_take_bit        = bus.valid_sampled_bit & w_last_sample;
  assign w_expected_parity = (^r_shift) ^ r_par_typ;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state        <= S_IDLE;
      r_sample_cnt   <= '0;
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      r_p_data       <= '0;
      r_par_en       <= 1'b0;
      r_par_typ      <= 1'b0;
      r_data_valid   <= 1'b0;
      r_parity_error <= 1'b0;
      r_stop_error   <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      if (r_state == S_IDLE) begin
        r_sample_cnt <= '0;
        r_bit_cnt    <= '0;
        if (!bus.RX_IN) begin
          r_state        <= S_START;
          r_par_en       <= bus.PAR_EN;
          r_par_typ      <= bus.PAR_TYP;
          r_parity_error <= 1'b0;
          r_stop_error   <= 1'b0;
          r_shift        <= '0;
        end
      end else begin
        if (w_last_sample) begin
          r_sample_cnt <= '0;
          r_bit_cnt    <= r_bit_cnt + c_BIT_ONE;
        end else begin
          r_sample_cnt <= r_sample_cnt + c_PS_ONE;
        end

        // Counter clears below override the increment when returning to IDLE.
        if (w_take_bit) begin
          case (r_state)
            S_START: begin
              if (bus.sampled_bit) begin
                r_state      <= S_IDLE;
                r_sample_cnt <= '0;
                r_bit_cnt    <= '0;
              end else begin
                r_state <= S_DATA;
              end
            end
            S_DATA: begin
              r_shift <= {bus.sampled_bit, r_shift[DATA_WIDTH-1:1]};
              if (r_bit_cnt == c_LAST_DATA_BIT) begin
                r_state <= r_par_en ? S_PARITY : S_STOP;
              end
            end
            S_PARITY: begin
              if (bus.sampled_bit != w_expected_parity) begin
                r_parity_error <= 1'b1;
              end
              r_state <= S_STOP;
            end
            S_STOP: begin
              if (!bus.sampled_bit) begin
                r_stop_error <= 1'b1;
              end else if (!r_parity_error) begin
                r_p_data     <= r_shift;
                r_data_valid <= 1'b1;
              end
              r_state      <= S_IDLE;
              r_sample_cnt <= '0;
              r_bit_cnt    <= '0;
            end
            default: begin
              r_state      <= S_IDLE;
              r_sample_cnt <= '0;
              r_bit_cnt    <= '0;
            end
          endcase
        end
      end
    end
  end

  assign bus.data_sampling_enable = (r_state == S_IDLE);
  assign bus.sample_counter       = r_sample_cnt;
  assign bus.bit_counter          = r_bit_cnt;
  assign bus.P_DATA               = r_p_data;
  assign bus.data_valid           = r_data_valid;
  assign bus.parity_error         = r_parity_error;
  assign bus.stop_error           = r_stop_error;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_frame_ctrl
//  Description : Randomised self-checking bench for uart_rx_frame_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   cyc = 0;

  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference state: last good byte and the sticky flags of the last frame.
  logic [7:0] m_pdata = 8'h00;
  logic       m_perr  = 1'b0;
  logic       m_serr  = 1'b0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  uart_rx_frame_ctrl_if #(.COUNTER_WIDTH(4), .PRESCALE_WIDTH(5), .DATA_WIDTH(8)) bus ();

  uart_rx_frame_ctrl #(.COUNTER_WIDTH(4), .PRESCALE_WIDTH(5), .DATA_WIDTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_dse"}, 32'(bus.data_sampling_enable), 1);
    check({tag, "_sc"},  32'(bus.sample_counter), 0);
    check({tag, "_bc"},  32'(bus.bit_counter), 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.RX_IN             = 1'b1;
      bus.valid_sampled_bit = 1'b0;
      tick;
      check("idle_dv",   32'(bus.data_valid), 0);
      check("idle_perr", 32'(bus.parity_error), 32'(m_perr));
      check("idle_serr", 32'(bus.stop_error), 32'(m_serr));
      check_idle_outputs("idle");
    end
  endtask

  // Drives one frame as the sampler would, starting from an IDLE cycle.
  // Returns the cycle number at which the frame result is checked.
  task automatic run_frame(input int ps, input bit pen, input bit ptyp,
                           input logic [7:0] data, input bit flip, input bit stop,
                           output int done_cyc);
    int          nbits;
    logic        par;
    logic [10:0] bits;
    logic        exp_dv;
    par   = (^data) ^ ptyp ^ flip;
    nbits = pen ? 11 : 10;
    bits  = pen ? {stop, par, data, 1'b0} : {1'b0, stop, data, 1'b0};

    bus.Prescale          = 5'(ps);
    bus.PAR_EN            = pen;
    bus.PAR_TYP           = ptyp;
    bus.RX_IN             = 1'b0;
    bus.valid_sampled_bit = 1'b0;
    tick;
    check("t0_sc",   32'(bus.sample_counter), 0);
    check("t0_bc",   32'(bus.bit_counter), 0);
    check("t0_dse",  32'(bus.data_sampling_enable), 0);
    check("t0_perr", 32'(bus.parity_error), 0);
    check("t0_serr", 32'(bus.stop_error), 0);

    // Parity configuration must be the one captured at start detection.
    bus.RX_IN   = 1'b1;
    bus.PAR_EN  = ~pen;
    bus.PAR_TYP = ~ptyp;
    for (int c = 0; c < nbits * ps; c++) begin
      check("frm_sc", 32'(bus.sample_counter), 32'(c % ps));
      check("frm_bc", 32'(bus.bit_counter), 32'(c / ps));
      check("frm_dv", 32'(bus.data_valid), 0);
      if (c % ps == ps - 1) begin
        bus.valid_sampled_bit = 1'b1;
        bus.sampled_bit       = bits[c / ps];
      end else if ($urandom_range(7) == 0) begin
        bus.valid_sampled_bit = 1'b1;
        bus.sampled_bit       = 1'($urandom_range(1));
      end else begin
        bus.valid_sampled_bit = 1'b0;
        bus.sampled_bit       = 1'($urandom_range(1));
      end
      tick;
    end
    bus.valid_sampled_bit = 1'b0;
    bus.PAR_EN            = pen;
    bus.PAR_TYP           = ptyp;

    m_perr = pen & flip;
    m_serr = ~stop;
    exp_dv = ~m_perr & ~m_serr;
    if (exp_dv) m_pdata = data;
    check("end_dv",    32'(bus.data_valid), 32'(exp_dv));
    check("end_pdata", 32'(bus.P_DATA), 32'(m_pdata));
    check("end_perr",  32'(bus.parity_error), 32'(m_perr));
    check("end_serr",  32'(bus.stop_error), 32'(m_serr));
    check_idle_outputs("end");
    done_cyc = cyc;
  endtask

  // RX_IN low for two cycles, start bit then voted high: a glitch.
  task automatic run_glitch(input int ps);
    bus.Prescale          = 5'(ps);
    bus.RX_IN             = 1'b0;
    bus.valid_sampled_bit = 1'b0;
    tick;
    check("gl_t0_dse", 32'(bus.data_sampling_enable), 0);
    for (int c = 0; c < ps; c++) begin
      bus.RX_IN             = (c == 0) ? 1'b0 : 1'b1;
      bus.valid_sampled_bit = (c == ps - 1);
      bus.sampled_bit       = 1'b1;
      tick;
    end
    bus.valid_sampled_bit = 1'b0;
    m_perr = 1'b0;
    m_serr = 1'b0;
    check("gl_dv",    32'(bus.data_valid), 0);
    check("gl_perr",  32'(bus.parity_error), 0);
    check("gl_serr",  32'(bus.stop_error), 0);
    check("gl_pdata", 32'(bus.P_DATA), 32'(m_pdata));
    check_idle_outputs("gl");
  endtask

  // Reset pulse while bit 4 of a frame is in progress.
  task automatic run_reset_abort(input int ps, input logic [7:0] data);
    logic [9:0] bits;
    bits                  = {1'b1, data, 1'b0};
    bus.Prescale          = 5'(ps);
    bus.PAR_EN            = 1'b0;
    bus.RX_IN             = 1'b0;
    bus.valid_sampled_bit = 1'b0;
    tick;
    bus.RX_IN = 1'b1;
    for (int c = 0; c < 4 * ps; c++) begin
      bus.valid_sampled_bit = (c % ps == ps - 1);
      bus.sampled_bit       = bits[c / ps];
      tick;
    end
    bus.valid_sampled_bit = 1'b0;
    check("rst_pre_bc", 32'(bus.bit_counter), 4);
    RST = 1'b1;
    tick;
    RST = 1'b0;
    m_pdata = 8'h00;
    m_perr  = 1'b0;
    m_serr  = 1'b0;
    check("rst_dv",    32'(bus.data_valid), 0);
    check("rst_pdata", 32'(bus.P_DATA), 0);
    check_idle_outputs("rst");
  endtask

  initial begin
    int t_a;
    int t_b;
    int ps;
    bus.RX_IN             = 1'b1;
    bus.PAR_EN            = 1'b0;
    bus.PAR_TYP           = 1'b0;
    bus.Prescale          = 5'd8;
    bus.valid_sampled_bit = 1'b0;
    bus.sampled_bit       = 1'b0;
    RST                   = 1'b1;
    repeat (3) tick;
    check("reset_dv",    32'(bus.data_valid), 0);
    check("reset_pdata", 32'(bus.P_DATA), 0);
    check("reset_perr",  32'(bus.parity_error), 0);
    check("reset_serr",  32'(bus.stop_error), 0);
    check_idle_outputs("reset");
    RST = 1'b0;
    idle(2);

    run_frame(8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, t_a);
    idle(3);
    run_frame(16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, t_a);
    idle(2);
    run_frame(16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, t_a);
    idle(2);
    run_frame(8, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, t_a);
    idle(2);
    run_glitch(8);
    idle(1);

    // Next start detected in the first IDLE cycle: the second t0 is the
    // cycle after the first pulse, so the second pulse follows 80+1 later.
    run_frame(8, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, t_a);
    run_frame(8, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b1, t_b);
    check("b2b_gap", 32'(t_b - t_a), 81);
    idle(2);

    run_reset_abort(8, 8'h3C);
    run_frame(8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, t_a);
    idle(1);

    for (int i = 0; i < 24; i++) begin
      ps = ($urandom_range(1) == 1) ? 16 : 8;
      if ($urandom_range(5) == 0) begin
        run_glitch(ps);
      end else begin
        run_frame(ps, 1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom),
                  ($urandom_range(3) == 0), ($urandom_range(3) != 0), t_a);
      end
      idle(int'($urandom_range(2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
